// File: rtl/fetch_pc_unit.sv
// Fetch PC register, single-outstanding instruction-memory request FSM and a small
// circular instruction buffer toward decode. Redirects flush the buffer and kill stale responses.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        if_ready,
  output logic [31:0] fetch_pc
);
  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [31:0]   req_addr_reg, req_addr_next;
  logic          kill_reg, kill_next;
  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [31:0]   buf_pc   [IBUF_DEPTH];
  logic [31:0]   buf_inst [IBUF_DEPTH];
  logic          push, pop, latch;
  logic [31:0]   redirect_target;
  logic          unused_pc_bits;

  // Low address bits of the redirect target are dropped; the fetch stream is word aligned.
  assign unused_pc_bits  = ^redirect_pc[1:0];
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // A redirect flushes the buffer, so neither a push nor a pop survives that edge.
  assign pop  = (count_reg != '0) && if_ready && !redirect_valid;
  assign push = (state_reg == WAIT) && imem_rsp_valid && !kill_reg && !redirect_valid;

  always_comb begin : count_calc
    count_next = count_reg;
    if (redirect_valid)
      count_next = '0;
    else if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (pop && !push)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_register
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // latch marks entry into REQ: capture the request address and advance the fetch PC.
  always_comb begin : next_state
    state_next = state_reg;
    latch      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (redirect_valid || (count_reg < DEPTH_C)) begin
          state_next = REQ;
          latch      = 1'b1;
        end
      end
      REQ: begin
        if (imem_req_ready)
          state_next = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (count_next < DEPTH_C) begin
            state_next = REQ;
            latch      = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin : outputs
    imem_req_valid = (state_reg == REQ);
    imem_req_addr  = req_addr_reg;
    if_valid       = (count_reg != '0);
    if_pc          = (count_reg != '0) ? buf_pc[rd_ptr_reg] : '0;
    if_inst        = (count_reg != '0) ? buf_inst[rd_ptr_reg] : NOP_INST;
    fetch_pc       = pc_reg;
  end

  // A response in WAIT always retires the one outstanding request, so kill clears there first.
  always_comb begin : datapath_next
    pc_next       = pc_reg;
    req_addr_next = req_addr_reg;
    kill_next     = kill_reg;
    if (latch) begin
      req_addr_next = redirect_valid ? redirect_target : pc_reg;
      pc_next       = (redirect_valid ? redirect_target : pc_reg) + 32'd4;
    end else if (redirect_valid) begin
      pc_next = redirect_target;
    end
    if ((state_reg == WAIT) && imem_rsp_valid)
      kill_next = 1'b0;
    else if (redirect_valid && (state_reg != IDLE))
      kill_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin : datapath_regs
    if (!rst_n) begin
      pc_reg       <= RESET_PC;
      req_addr_reg <= '0;
      kill_reg     <= 1'b0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      pc_reg       <= pc_next;
      req_addr_reg <= req_addr_next;
      kill_reg     <= kill_next;
      count_reg    <= count_next;
      if (redirect_valid) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push)
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin : buffer_write
    if (push) begin
      buf_pc[wr_ptr_reg]   <= req_addr_reg;
      buf_inst[wr_ptr_reg] <= imem_rsp_data;
    end
  end

endmodule
